// File: rtl/result_bcd_converter.sv
// result_bcd_converter: serial double-dabble conversion of a 20-bit signed-magnitude result to six saturated BCD digits.
module result_bcd_converter (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [19:0] binaryIn,
  input  logic        signIn,
  output logic [23:0] bcdOut,
  output logic        signOut,
  output logic        overflow,
  output logic        busy,
  output logic        done
);
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
  state_t      r_state, w_next;
  logic [19:0] r_shift;
  logic [23:0] r_scratch, w_adj;
  logic [4:0]  r_cnt;
  logic        r_sign, r_ovf;
  for (genvar d = 0; d < 6; d++) begin : g_adj
    assign w_adj[4*d +: 4] = r_scratch[4*d +: 4] >= 4'd5 ? r_scratch[4*d +: 4] + 4'd3 : r_scratch[4*d +: 4];
  end
  always_comb begin
    w_next = IDLE;
    w_next = r_state == IDLE  ? (start ? SHIFT : IDLE) :
             r_state == SHIFT ? (r_cnt == 5'd19 ? DONE : SHIFT) : IDLE;
  end
  assign busy = r_state != IDLE;
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_shift   <= '0;
      r_scratch <= '0;
      r_cnt     <= '0;
      r_sign    <= 1'b0;
      r_ovf     <= 1'b0;
      bcdOut    <= '0;
      signOut   <= 1'b0;
      overflow  <= 1'b0;
      done      <= 1'b0;
    end else begin
      r_state <= w_next;
      done    <= 1'b0;
      if (r_state == IDLE && start) begin
        r_shift   <= binaryIn;
        r_scratch <= '0;
        r_cnt     <= '0;
        r_sign    <= signIn & (|binaryIn);
        r_ovf     <= binaryIn > 20'd999999;
      end
      if (r_state == SHIFT) begin
        r_scratch <= {w_adj[22:0], r_shift[19]};
        r_shift   <= {r_shift[18:0], 1'b0};
        r_cnt     <= r_cnt + 5'd1;
      end
      if (r_state == DONE) begin
        bcdOut   <= r_ovf ? 24'h999999 : r_scratch;
        signOut  <= r_sign;
        overflow <= r_ovf;
        done     <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_result_bcd_converter.sv
// tb_result_bcd_converter: directed vectors with hand-computed BCD results, latency and control checks.
module tb_result_bcd_converter;
  logic        clock = 1'b0;
  logic        reset, start, signIn;
  logic [19:0] binaryIn;
  logic [23:0] bcdOut;
  logic        signOut, overflow, busy, done;
  int          checks = 0;
  int          errors = 0;
  int          cyc, nb, nd;

  result_bcd_converter dut (
    .clock(clock), .reset(reset), .start(start), .binaryIn(binaryIn), .signIn(signIn),
    .bcdOut(bcdOut), .signOut(signOut), .overflow(overflow), .busy(busy), .done(done)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic run(input logic [19:0] v, input logic s, input logic [23:0] eb, input logic es, input logic eo);
    @(negedge clock);
    binaryIn = v; signIn = s; start = 1'b1;
    @(negedge clock);
    start = 1'b0; binaryIn = ~v; signIn = ~s;
    cyc = 1; nb = int'(busy);
    while (!done && cyc < 40) begin
      @(negedge clock);
      cyc++;
      nb += int'(busy);
    end
    chk("latency", cyc, 22);
    chk("busy_cycles", nb, 21);
    chk("bcd", bcdOut, eb);
    chk("sign", signOut, es);
    chk("ovf", overflow, eo);
    @(negedge clock);
    chk("done_one_cycle", done, 1'b0);
    chk("hold_bcd", bcdOut, eb);
  endtask

  initial begin
    reset = 1'b1; start = 1'b1; binaryIn = 20'd5; signIn = 1'b1;
    repeat (2) @(negedge clock);
    chk("rst_bcd", bcdOut, 24'h0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_sign_ovf", {signOut, overflow}, 2'b00);
    reset = 1'b0; start = 1'b0;

    run(20'd0,       1'b1, 24'h000000, 1'b0, 1'b0);
    run(20'd998001,  1'b0, 24'h998001, 1'b0, 1'b0);
    run(20'd12345,   1'b1, 24'h012345, 1'b1, 1'b0);
    run(20'd1000000, 1'b0, 24'h999999, 1'b0, 1'b1);
    run(20'd999999,  1'b1, 24'h999999, 1'b1, 1'b0);
    run(20'd1048575, 1'b1, 24'h999999, 1'b1, 1'b1);
    run(20'd90909,   1'b0, 24'h090909, 1'b0, 1'b0);

    // a second start mid-conversion must be dropped
    @(negedge clock);
    binaryIn = 20'd12345; signIn = 1'b0; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (4) @(negedge clock);
    binaryIn = 20'd777; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    nd = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (done) begin
        nd++;
        chk("ignored_start_bcd", bcdOut, 24'h012345);
      end
    end
    chk("ignored_start_pulses", nd, 1);
    chk("ignored_start_idle", busy, 1'b0);

    // reset in the middle of a conversion aborts it
    @(negedge clock);
    binaryIn = 20'd654321; signIn = 1'b1; start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    repeat (10) @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_bcd", bcdOut, 24'h0);
    chk("abort_busy", busy, 1'b0);
    chk("abort_flags", {signOut, overflow, done}, 3'b000);
    nd = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clock);
      nd += int'(done);
    end
    chk("abort_no_done", nd, 0);
    run(20'd42, 1'b0, 24'h000042, 1'b0, 1'b0);

    // reset wins over a simultaneous start
    @(negedge clock);
    reset = 1'b1; start = 1'b1; binaryIn = 20'd9;
    @(negedge clock);
    reset = 1'b0; start = 1'b0;
    chk("rst_prio_busy", busy, 1'b0);
    chk("rst_prio_bcd", bcdOut, 24'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/result_bcd_converter.md
RESULT_BCD_CONVERTER -- requirements
Module: result_bcd_converter

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed below.
REQ-002 clock  in  1  sole clock; all state SHALL update on its rising edge.
REQ-003 reset  in  1  synchronous, active-high reset, sampled on the rising edge of clock.
REQ-004 start  in  1  request a conversion; sampled only in IDLE.
REQ-005 binaryIn  in  20  unsigned magnitude of the arithmetic result (ALU outputNumber).
REQ-006 signIn  in  1  sign of the result; 1 = negative (ALU signOut).
REQ-007 bcdOut  out  24  six packed BCD digits; [23:20] = hundred-thousands, [3:0] = units.
REQ-008 signOut  out  1  display sign for the converted value.
REQ-009 overflow  out  1  the latched magnitude exceeded 999999.
REQ-010 busy  out  1  high whenever the state is not IDLE.
REQ-011 done  out  1  single-cycle pulse that marks new bcdOut/signOut/overflow values.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, SHIFT and DONE.
REQ-013 IDLE with start=1: latch binaryIn into a 20-bit shift register and signIn into a sign register; clear the 24-bit BCD scratch register and the 5-bit bit counter; go to SHIFT.
REQ-014 IDLE with start=0: remain in IDLE; all outputs hold.
REQ-015 Each SHIFT cycle (double-dabble step):
- add 3 to every scratch nibble that is >= 5;
- then shift {scratch, shift register} left by one bit;
- increment the counter.
REQ-016 After the 20th SHIFT cycle (counter reaching 20), go to DONE.
REQ-017 On entry to DONE, the block SHALL register bcdOut, signOut and overflow and assert done for exactly that one cycle; the next state is IDLE.
REQ-018 Latency: start sampled at edge N gives done=1 in the cycle after edge N+21, with outputs valid in that same cycle.
REQ-019 Overflow: if the latched magnitude > 999999 (values up to 1048575 are possible):
- overflow = 1;
- bcdOut = 24'h999999 (saturated).
REQ-020 Otherwise overflow = 0 and bcdOut = the exact BCD value.
REQ-021 signOut = latched sign AND (magnitude != 0); negative zero SHALL display as positive zero.
REQ-022 bcdOut, signOut and overflow SHALL hold their last values until the next DONE cycle or reset.
REQ-023 start SHALL be ignored in SHIFT and DONE (no queuing); a start in the DONE cycle is dropped.
REQ-024 binaryIn and signIn SHALL be sampled only on the accepting edge; later input changes SHALL NOT affect the conversion in progress.
REQ-025 No BCD nibble of bcdOut SHALL ever exceed 9.

Reset
REQ-026 reset=1 SHALL force IDLE and clear bcdOut, signOut, overflow, busy, done, the scratch register, the shift register and the counter.
REQ-027 Reset SHALL take priority over start in the same cycle and SHALL abort any conversion in progress; done SHALL NOT pulse for an aborted conversion.
REQ-028 The first start after reset is deasserted SHALL be accepted normally.

Verification
REQ-029 binaryIn=0, signIn=1, start pulse -> after 21 cycles done=1, bcdOut=24'h000000, signOut=0, overflow=0.
REQ-030 binaryIn=998001, signIn=0 -> bcdOut=24'h998001, signOut=0, overflow=0; busy high for 21 cycles.
REQ-031 binaryIn=12345, signIn=1 -> bcdOut=24'h012345, signOut=1.
REQ-032 binaryIn=1000000 -> overflow=1, bcdOut=24'h999999.
REQ-033 Start 12345; change binaryIn to 777 and pulse start at cycle 5 -> result 24'h012345, exactly one done pulse, the second start is ignored.
REQ-034 Reset at SHIFT cycle 10 -> next cycle all outputs 0, state IDLE, no done pulse; a fresh start with 42 -> bcdOut=24'h000042.
